// File: rtl/am_cfg_sched_pkg.sv
// Shared types and default tuning constants for the AM config scheduler.
// Also reused by the AM generator for its reset tuning words.
package am_cfg_sched_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DWELL = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_FS    = 2'd0,
    MODE_FC    = 2'd1,
    MODE_DEPTH = 2'd2
  } mode_e;

  localparam int          AM_PHASE_W   = 32;
  localparam logic [31:0] AM_FC_DEFAULT = 32'h0400_0000;
  localparam logic [31:0] AM_FC_MIN     = 32'h0100_0000;
  localparam logic [31:0] AM_FC_MAX     = 32'h1000_0000;
  localparam logic [31:0] AM_FC_STEP    = 32'h0010_0000;
  localparam logic [31:0] AM_FS_MIN     = 32'h0001_0000;
  localparam logic [31:0] AM_FS_MAX     = 32'h0040_0000;
  localparam logic [31:0] AM_FS_STEP    = 32'h0001_0000;
  localparam logic [7:0]  AM_DEPTH_MAX  = 8'd255;

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_FS:  next_mode = MODE_FC;
      MODE_FC:  next_mode = MODE_DEPTH;
      default:  next_mode = MODE_FS;
    endcase
  endfunction

endpackage

// File: rtl/am_cfg_sched_sat_step.sv
// Saturating up/down step of one tuning quantity.
// Computes in W+1 bits so neither direction can wrap.
module sat_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_value,
  input  logic [W-1:0] i_step,
  input  logic [W-1:0] i_lo,
  input  logic [W-1:0] i_hi,
  input  logic         i_up,
  input  logic         i_down,
  output logic [W-1:0] o_next,
  output logic         o_changed
);

  logic [W:0] w_sum;
  logic [W:0] w_floor;

  assign w_sum   = {1'b0, i_value} + {1'b0, i_step};
  assign w_floor = {1'b0, i_lo} + {1'b0, i_step};

  always_comb begin
    o_next = i_value;
    if (i_up && !i_down) begin
      if (w_sum > {1'b0, i_hi}) o_next = i_hi;
      else                      o_next = w_sum[W-1:0];
    end else if (i_down && !i_up) begin
      if ({1'b0, i_value} < w_floor) o_next = i_lo;
      else                           o_next = i_value - i_step;
    end
  end

  assign o_changed = (o_next != i_value);

endmodule

// File: rtl/am_cfg_sched.sv
// Turns key pulses and an optional fs sweep into validated
// DDS configuration updates delivered over valid/ready.
module am_cfg_sched
  import am_cfg_sched_pkg::*;
#(
  parameter int                 PHASE_W    = AM_PHASE_W,
  parameter logic [PHASE_W-1:0] FC_DEFAULT = AM_FC_DEFAULT,
  parameter logic [PHASE_W-1:0] FC_MIN     = AM_FC_MIN,
  parameter logic [PHASE_W-1:0] FC_MAX     = AM_FC_MAX,
  parameter logic [PHASE_W-1:0] FC_STEP    = AM_FC_STEP,
  parameter logic [PHASE_W-1:0] FS_MIN     = AM_FS_MIN,
  parameter logic [PHASE_W-1:0] FS_MAX     = AM_FS_MAX,
  parameter logic [PHASE_W-1:0] FS_STEP    = AM_FS_STEP,
  parameter int                 DEPTH_STEP = 16,
  parameter int                 DWELL      = 1_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_up,
  input  logic               key_down,
  input  logic               key_mode,
  input  logic               sweep_en,
  input  logic               cfg_ready,
  output logic               cfg_valid,
  output logic [PHASE_W-1:0] fc_word,
  output logic [PHASE_W-1:0] fs_word,
  output logic [7:0]         depth,
  output logic [1:0]         mode,
  output logic               busy
);

  localparam int CW = (DWELL > 2) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  state_e             r_state, w_nstate;
  mode_e              r_mode, w_mode;
  logic [PHASE_W-1:0] r_fc, w_fc, r_fs, w_fs;
  logic [7:0]         r_dp, w_dp;
  logic [CW-1:0]      r_cnt, w_cnt;
  logic               r_valid, r_busy;

  logic [PHASE_W-1:0] w_fs_nxt, w_fc_nxt, w_fs_wrap;
  logic [7:0]         w_dp_nxt;
  logic               w_fs_chg, w_fc_chg, w_dp_chg;
  logic [PHASE_W:0]   w_fs_sum;

  sat_step #(.W(PHASE_W)) u_fs (
    .i_value(r_fs), .i_step(FS_STEP),
    .i_lo(FS_MIN), .i_hi(FS_MAX),
    .i_up(key_up), .i_down(key_down),
    .o_next(w_fs_nxt), .o_changed(w_fs_chg)
  );

  sat_step #(.W(PHASE_W)) u_fc (
    .i_value(r_fc), .i_step(FC_STEP),
    .i_lo(FC_MIN), .i_hi(FC_MAX),
    .i_up(key_up), .i_down(key_down),
    .o_next(w_fc_nxt), .o_changed(w_fc_chg)
  );

  sat_step #(.W(8)) u_dp (
    .i_value(r_dp), .i_step(8'(DEPTH_STEP)),
    .i_lo(8'd0), .i_hi(AM_DEPTH_MAX),
    .i_up(key_up), .i_down(key_down),
    .o_next(w_dp_nxt), .o_changed(w_dp_chg)
  );

  // Sweep wraps to the bottom instead of saturating
  assign w_fs_sum  = {1'b0, r_fs} + {1'b0, FS_STEP};
  assign w_fs_wrap = (w_fs_sum > {1'b0, FS_MAX}) ?
                     FS_MIN : w_fs_sum[PHASE_W-1:0];

  always_comb begin
    w_nstate = r_state;
    w_mode   = r_mode;
    w_fc     = r_fc;
    w_fs     = r_fs;
    w_dp     = r_dp;
    w_cnt    = r_cnt;
    unique case (r_state)
      ST_INIT: w_nstate = ST_LOAD;
      ST_IDLE: begin
        if (sweep_en) begin
          w_nstate = ST_DWELL;
          w_cnt    = '0;
        end else if (key_mode) begin
          w_mode = next_mode(r_mode);
        end else begin
          case (r_mode)
            MODE_FS: if (w_fs_chg) begin
              w_fs     = w_fs_nxt;
              w_nstate = ST_LOAD;
            end
            MODE_FC: if (w_fc_chg) begin
              w_fc     = w_fc_nxt;
              w_nstate = ST_LOAD;
            end
            MODE_DEPTH: if (w_dp_chg) begin
              w_dp     = w_dp_nxt;
              w_nstate = ST_LOAD;
            end
            default: ;
          endcase
        end
      end
      ST_LOAD: begin
        if (cfg_ready) begin
          w_nstate = sweep_en ? ST_DWELL : ST_IDLE;
          w_cnt    = '0;
        end
      end
      ST_DWELL: begin
        if (!sweep_en) begin
          w_nstate = ST_IDLE;
          w_cnt    = '0;
        end else if (r_cnt == LAST) begin
          w_fs     = w_fs_wrap;
          w_nstate = ST_LOAD;
          w_cnt    = '0;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      default: w_nstate = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
      r_mode  <= MODE_FS;
      r_fc    <= FC_DEFAULT;
      r_fs    <= FS_MIN;
      r_dp    <= AM_DEPTH_MAX;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_mode  <= w_mode;
      r_fc    <= w_fc;
      r_fs    <= w_fs;
      r_dp    <= w_dp;
      r_cnt   <= w_cnt;
      r_valid <= (w_nstate == ST_LOAD);
      r_busy  <= (w_nstate != ST_IDLE);
    end
  end

  assign cfg_valid = r_valid;
  assign fc_word   = r_fc;
  assign fs_word   = r_fs;
  assign depth     = r_dp;
  assign mode      = r_mode;
  assign busy      = r_busy;

endmodule
